// File: rtl/canny_pkg.sv
// canny_pkg: shared pixel and window types for the Canny pipeline
package canny_pkg;
    localparam int PIX_W = 8;
    localparam int WIN = 9;
    localparam int CNT_W = 4;
    typedef logic [PIX_W-1:0] pixel_t;
    typedef pixel_t [WIN-1:0] win_row_t;
endpackage

// File: rtl/pixel_window_buffer_if.sv
// pixel_window_buffer_if: controller qualifiers, SRAM read data and window outputs
interface pixel_window_buffer_if;
    import canny_pkg::*;
    logic clear;
    logic col_push;
    logic row_push;
    logic dir_left;
    pixel_t rd_a, rd_b, rd_c, rd_d, rd_e, rd_f, rd_g, rd_h, rd_i;
    logic [WIN*WIN*PIX_W-1:0] window;
    logic window_valid;
    logic [CNT_W-1:0] col_count;
    logic err_collision;
    modport master (
        output clear, col_push, row_push, dir_left,
        output rd_a, rd_b, rd_c, rd_d, rd_e, rd_f, rd_g, rd_h, rd_i,
        input window, window_valid, col_count, err_collision
    );
    modport slave (
        input clear, col_push, row_push, dir_left,
        input rd_a, rd_b, rd_c, rd_d, rd_e, rd_f, rd_g, rd_h, rd_i,
        output window, window_valid, col_count, err_collision
    );
endinterface

// File: rtl/pixel_window_buffer_qual_delay.sv
// qual_delay: DEPTH-stage shift register aligning qualifiers to the SRAM read latency
module qual_delay #(
    parameter int DEPTH = 1,
    parameter int W = 3
) (
    input logic clk,
    input logic n_rst,
    input logic clear,
    input logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [DEPTH-1:0][W-1:0] sr;
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst)
            sr <= '0;
        else if (clear)
            sr <= '0;
        else begin
            for (int k = DEPTH - 1; k > 0; k--)
                sr[k] <= sr[k-1];
            sr[0] <= d;
        end
    assign q = sr[DEPTH-1];
endmodule

// File: rtl/pixel_window_buffer.sv
// pixel_window_buffer: assembles the 9x9 Gaussian window from column/row SRAM reads
module pixel_window_buffer
    import canny_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input logic clk,
    input logic n_rst,
    pixel_window_buffer_if.slave bus
);
    win_row_t [WIN-1:0] win, win_nxt;
    win_row_t rd;
    logic col_d, row_d, dir_d;
    logic [CNT_W-1:0] col_count;
    logic err_collision;
    assign rd = {bus.rd_i, bus.rd_h, bus.rd_g, bus.rd_f, bus.rd_e,
                 bus.rd_d, bus.rd_c, bus.rd_b, bus.rd_a};
    qual_delay #(.DEPTH(RD_LAT), .W(3)) u_qual (
        .clk(clk),
        .n_rst(n_rst),
        .clear(bus.clear),
        .d({bus.col_push, bus.row_push, bus.dir_left}),
        .q({col_d, row_d, dir_d})
    );
    // Column pushes shift each row sideways; a row push scrolls the whole window up.
    always_comb begin
        win_nxt = win;
        for (int r = 0; r < WIN; r++)
            if (col_d && !row_d)
                win_nxt[r] = dir_d ? {win[r][WIN-2:0], rd[r]} : {rd[r], win[r][WIN-1:1]};
        if (row_d && !col_d)
            win_nxt = {rd, win[WIN-1:1]};
    end
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            win <= '0;
            col_count <= '0;
            err_collision <= 1'b0;
        end else if (bus.clear) begin
            win <= '0;
            col_count <= '0;
            err_collision <= 1'b0;
        end else begin
            win <= win_nxt;
            if (col_d && !row_d && col_count != CNT_W'(WIN))
                col_count <= col_count + 1'b1;
            if (col_d && row_d)
                err_collision <= 1'b1;
        end
    assign bus.window = win;
    assign bus.col_count = col_count;
    assign bus.window_valid = col_count == CNT_W'(WIN);
    assign bus.err_collision = err_collision;
endmodule
